// File: rtl/char_rom_pkg.sv
// char_rom_pkg: shared widths, geometry default and pipeline tag types for the glyph ROM arbiter.
package char_rom_pkg;
  localparam int CHAR_W = 7;
  localparam int ROW_W = 4;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;
  localparam int DEF_ROWS_PER_CHAR = 9;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VID = 2'd1, OWN_AUX = 2'd2} owner_t;
  typedef struct packed {
    owner_t owner;
    logic blank;
  } tag_t;
endpackage

// File: rtl/char_rom_arbiter_if.sv
// char_rom_arbiter_if: video, aux and ROM-port signals of the glyph ROM arbiter.
interface char_rom_arbiter_if;
  import char_rom_pkg::*;
  logic vid_req;
  logic [CHAR_W-1:0] vid_char;
  logic [ROW_W-1:0] vid_row;
  logic vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic aux_req;
  logic [CHAR_W-1:0] aux_char;
  logic [ROW_W-1:0] aux_row;
  logic aux_ack;
  logic aux_valid;
  logic [DATA_W-1:0] aux_data;
  logic aux_starved;
  logic rom_ce;
  logic [ADDR_W-1:0] rom_ad;
  logic [DATA_W-1:0] rom_dout;
  modport slave (
    input vid_req, vid_char, vid_row, aux_req, aux_char, aux_row, rom_dout,
    output vid_valid, vid_data, aux_ack, aux_valid, aux_data, aux_starved, rom_ce, rom_ad
  );
  modport master (
    output vid_req, vid_char, vid_row, aux_req, aux_char, aux_row, rom_dout,
    input vid_valid, vid_data, aux_ack, aux_valid, aux_data, aux_starved, rom_ce, rom_ad
  );
endinterface

// File: rtl/char_addr_calc.sv
// char_addr_calc: maps (glyph, scan row) to a ROM address and flags rows outside the glyph.
module char_addr_calc import char_rom_pkg::*; #(
  parameter int ROWS_PER_CHAR = DEF_ROWS_PER_CHAR
) (
  input  logic [CHAR_W-1:0] chr,
  input  logic [ROW_W-1:0]  row,
  output logic [ADDR_W-1:0] addr,
  output logic              blank
);
  logic [ADDR_W-1:0] c, r;
  always_comb begin
    c = ADDR_W'(chr);
    r = ADDR_W'(row);
    addr = (ROWS_PER_CHAR == 9) ? (c << 3) + c + r : c * ADDR_W'(ROWS_PER_CHAR) + r;
    blank = int'(row) >= ROWS_PER_CHAR;
  end
endmodule

// File: rtl/char_rom_arbiter.sv
// char_rom_arbiter: shares the glyph ROM read port between video (strict priority) and aux,
// returning each owner's data at a fixed 2-cycle latency via a tag carried alongside the read.
module char_rom_arbiter import char_rom_pkg::*; #(
  parameter int ROWS_PER_CHAR = DEF_ROWS_PER_CHAR,
  parameter int NUM_CHARS = 128,
  parameter int STARVE_LIMIT = 255
) (
  input logic clk,
  input logic reset,
  char_rom_arbiter_if.slave bus
);
  if (NUM_CHARS * ROWS_PER_CHAR > 2048 || STARVE_LIMIT > 255)
    $error("char_rom_arbiter: geometry exceeds ROM or starve limit exceeds counter");
  logic grant_vid, grant_aux, go, blank, row_blank;
  logic [CHAR_W-1:0] sel_char;
  logic [ROW_W-1:0] sel_row;
  logic [ADDR_W-1:0] addr;
  logic [7:0] wait_cnt, wait_nxt;
  tag_t tag_a, tag_b;
  // an aux request acked last cycle is still high while the requester drops it
  always_comb begin
    grant_vid = bus.vid_req;
    grant_aux = !bus.vid_req && bus.aux_req && !bus.aux_ack;
    go = grant_vid || grant_aux;
    sel_char = grant_vid ? bus.vid_char : bus.aux_char;
    sel_row = grant_vid ? bus.vid_row : bus.aux_row;
    blank = go && row_blank;
    wait_nxt = (!bus.aux_req || grant_aux) ? 8'd0 : (wait_cnt == 8'hff ? wait_cnt : wait_cnt + 8'd1);
  end
  char_addr_calc #(.ROWS_PER_CHAR(ROWS_PER_CHAR)) u_addr (
    .chr(sel_char), .row(sel_row), .addr(addr), .blank(row_blank)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rom_ce <= 1'b0;
      bus.rom_ad <= '0;
      bus.aux_ack <= 1'b0;
      bus.vid_valid <= 1'b0;
      bus.aux_valid <= 1'b0;
      bus.vid_data <= '0;
      bus.aux_data <= '0;
      bus.aux_starved <= 1'b0;
      tag_a <= '0;
      tag_b <= '0;
      wait_cnt <= '0;
    end else begin
      bus.rom_ce <= go && !blank;
      if (go && !blank) bus.rom_ad <= addr;
      bus.aux_ack <= grant_aux;
      tag_a <= '{owner: grant_vid ? OWN_VID : (grant_aux ? OWN_AUX : OWN_NONE), blank: blank};
      tag_b <= tag_a;
      bus.vid_valid <= tag_b.owner == OWN_VID;
      bus.aux_valid <= tag_b.owner == OWN_AUX;
      if (tag_b.owner == OWN_VID) bus.vid_data <= tag_b.blank ? '0 : bus.rom_dout;
      if (tag_b.owner == OWN_AUX) bus.aux_data <= tag_b.blank ? '0 : bus.rom_dout;
      wait_cnt <= wait_nxt;
      bus.aux_starved <= int'(wait_nxt) >= STARVE_LIMIT;
    end
endmodule
